// File: rtl/lsu_mem_if.sv
// Request/response and dmem signals between the MEM stage, the LSU and data memory.
// The slave modport is the LSU side; master is the pipeline/dmem side.
interface lsu_mem_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic            is_load;
   logic            is_store;
   logic [2:0]      funct3;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] store_data;
   logic            resp_valid;
   logic [XLEN-1:0] load_data;
   logic            fault;
   logic [XLEN-1:0] mem_address;
   logic            mem_read;
   logic            mem_write;
   logic [XLEN-1:0] mem_write_data;
   logic [XLEN-1:0] mem_read_data;

   modport slave (
      input  req_valid, is_load, is_store, funct3, addr, store_data, mem_read_data,
      output req_ready, resp_valid, load_data, fault,
      output mem_address, mem_read, mem_write, mem_write_data
   );

   modport master (
      output req_valid, is_load, is_store, funct3, addr, store_data, mem_read_data,
      input  req_ready, resp_valid, load_data, fault,
      input  mem_address, mem_read, mem_write, mem_write_data
   );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV64I load/store unit: maps byte/half/word/double accesses onto a doubleword-wide
// dmem without byte enables, using read-modify-write for sub-doubleword stores.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a request; req_ready high
// S_READ  | dmem read of the addressed doubleword, captured in rdata_q
// S_WRITE | one-cycle dmem write of the merged (or full) doubleword
// S_RESP  | resp_valid pulse with load_data / fault
module lsu_mem_stage #(
   parameter int XLEN       = 64,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic      clk,
   input  logic      reset,
   lsu_mem_if.slave  bus
);

   localparam int IDX_W = $clog2(DMEM_DEPTH);

   generate
      if (DMEM_DEPTH < 2 || IDX_W > XLEN - 3) begin : g_bad_cfg
         $error("lsu_mem_stage: DMEM_DEPTH does not fit the doubleword index");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } state_t;

   state_t          state_q;
   state_t          state_d;

   logic [XLEN-1:0] addr_q;
   logic [2:0]      funct3_q;
   logic [XLEN-1:0] store_data_q;
   logic            is_load_q;
   logic            is_store_q;
   logic            fault_q;
   logic [XLEN-1:0] rdata_q;

   logic            accept;
   logic            misalign;
   logic            req_fault;

   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     ld_word;
   logic [XLEN-1:0] ld_ext;

   logic [5:0]      lane_shift;
   logic [XLEN-1:0] lane_mask;
   logic [XLEN-1:0] merged;

   // Outputs are forced low while reset is held so an abandoned access cannot write.
   assign accept        = bus.req_valid && (state_q == S_IDLE) && !reset;
   assign bus.req_ready = (state_q == S_IDLE) && !reset;

   always_comb begin
      misalign = 1'b0;
      case (bus.funct3)
         3'b001, 3'b101: misalign = bus.addr[0];
         3'b010, 3'b110: misalign = |bus.addr[1:0];
         3'b011:         misalign = |bus.addr[2:0];
         default:        misalign = 1'b0;
      endcase
      req_fault = misalign
               || (bus.funct3 == 3'b111)
               || (bus.is_store && bus.funct3[2])
               || (bus.is_load == bus.is_store);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         funct3_q     <= '0;
         store_data_q <= '0;
         is_load_q    <= 1'b0;
         is_store_q   <= 1'b0;
         fault_q      <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q       <= bus.addr;
            funct3_q     <= bus.funct3;
            store_data_q <= bus.store_data;
            is_load_q    <= bus.is_load;
            is_store_q   <= bus.is_store;
            fault_q      <= req_fault;
         end
         if (state_q == S_READ) begin
            rdata_q <= bus.mem_read_data;
         end
      end
   end

   // Field extraction for loads; lanes are aligned because misaligned requests fault.
   always_comb begin
      ld_byte = rdata_q[{addr_q[2:0], 3'b000} +: 8];
      ld_half = rdata_q[{addr_q[2:1], 4'b0000} +: 16];
      ld_word = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
      ld_ext  = '0;
      case (funct3_q[1:0])
         2'b00:   ld_ext = funct3_q[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                       : {{(XLEN-8){ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = funct3_q[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                       : {{(XLEN-16){ld_half[15]}}, ld_half};
         2'b10:   ld_ext = funct3_q[2] ? {{(XLEN-32){1'b0}}, ld_word}
                                       : {{(XLEN-32){ld_word[31]}}, ld_word};
         default: ld_ext = rdata_q;
      endcase
   end

   // SD takes the full-width mask with zero shift, so it passes store_data straight through.
   always_comb begin
      lane_shift = {addr_q[2:0], 3'b000};
      lane_mask  = '1;
      case (funct3_q[1:0])
         2'b00:   lane_mask = {{(XLEN-8){1'b0}}, 8'hFF};
         2'b01:   lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
         2'b10:   lane_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
         default: lane_mask = '1;
      endcase
      merged = (rdata_q & ~(lane_mask << lane_shift))
             | ((store_data_q & lane_mask) << lane_shift);
   end

   always_comb begin
      state_d            = state_q;
      bus.resp_valid     = 1'b0;
      bus.load_data      = '0;
      bus.fault          = 1'b0;
      bus.mem_address    = '0;
      bus.mem_read       = 1'b0;
      bus.mem_write      = 1'b0;
      bus.mem_write_data = '0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (req_fault)                  state_d = S_RESP;
               else if (bus.is_load)           state_d = S_READ;
               else if (bus.funct3 == 3'b011)  state_d = S_WRITE;
               else                            state_d = S_READ;
            end
         end
         S_READ: begin
            if (is_load_q)       state_d = S_RESP;
            else if (is_store_q) state_d = S_WRITE;
            else                 state_d = S_RESP;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (!reset) begin
         if (state_q != S_IDLE) begin
            bus.mem_address = {3'b000, addr_q[XLEN-1:3]};
         end
         case (state_q)
            S_READ:  bus.mem_read = 1'b1;
            S_WRITE: begin
               bus.mem_write      = 1'b1;
               bus.mem_write_data = merged;
            end
            S_RESP: begin
               bus.resp_valid = 1'b1;
               bus.fault      = fault_q;
               if (is_load_q && !fault_q) begin
                  bus.load_data = ld_ext;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: vector table plus a response scoreboard
// and hand sequences for reset-abandon and held-valid back-to-back loads.
module tb_lsu_mem_stage;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   lsu_mem_if #(.XLEN(64)) bus ();

   lsu_mem_stage #(.XLEN(64), .DMEM_DEPTH(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [63:0] dmem [1024];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_idx = '0;
   logic [63:0] pl_val = '0;

   assign bus.mem_read_data = dmem[bus.mem_address[9:0]];

   always @(posedge clk) begin
      if (pl_en) dmem[pl_idx] <= pl_val;
      else if (bus.mem_write) dmem[bus.mem_address[9:0]] <= bus.mem_write_data;
   end

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] sd;
      logic [63:0] exp_data;
      logic        exp_fault;
      int          lat;
      logic        exp_rd;
      int          wr_cyc;
   } vec_t;

   typedef struct {
      logic [63:0] data;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[23];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected actual=1 required=0");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("load_data", bus.load_data, e.data);
            chk("fault", {63'd0, bus.fault}, {63'd0, e.fault});
         end
      end
   end

   task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] sd);
      bus.req_valid  = 1'b1;
      bus.is_load    = ld;
      bus.is_store   = st;
      bus.funct3     = f3;
      bus.addr       = a;
      bus.store_data = sd;
   endtask

   task automatic scramble();
      bus.req_valid  = 1'b0;
      bus.is_load    = 1'($urandom);
      bus.is_store   = 1'($urandom);
      bus.funct3     = 3'($urandom);
      bus.addr       = {$urandom, $urandom};
      bus.store_data = {$urandom, $urandom};
   endtask

   task automatic apply(input int n, input vec_t v);
      int   lat;
      int   wr_cnt;
      int   wr_at;
      logic saw_rd;
      lat = 0; wr_cnt = 0; wr_at = 0; saw_rd = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_req_ready", n), {63'd0, bus.req_ready}, 64'd1);
      drive(v.ld, v.st, v.f3, v.addr, v.sd);
      exp_q.push_back('{data: v.exp_data, fault: v.exp_fault});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) scramble();
         if (bus.mem_read) saw_rd = 1'b1;
         if (bus.mem_write) begin
            wr_cnt++;
            wr_at = k;
         end
         if (bus.resp_valid) begin
            lat = k;
            break;
         end
      end
      chk($sformatf("v%0d_latency", n), 64'(lat), 64'(v.lat));
      chk($sformatf("v%0d_mem_read", n), {63'd0, saw_rd}, {63'd0, v.exp_rd});
      chk($sformatf("v%0d_write_count", n), 64'(wr_cnt), (v.wr_cyc != 0) ? 64'd1 : 64'd0);
      chk($sformatf("v%0d_write_cycle", n), 64'(wr_at), 64'(v.wr_cyc));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int   wr_cnt;
      int   rv_cnt;
      logic [7:0] rv;
      logic [7:0] rdy;

      // ld st f3 addr sd exp_data fault lat rd wr
      vecs[0]  = '{1, 0, 3'b000, 64'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 0, 2, 1, 0};
      vecs[1]  = '{1, 0, 3'b100, 64'h17, 64'h0, 64'h0000_0000_0000_0088, 0, 2, 1, 0};
      vecs[2]  = '{1, 0, 3'b001, 64'h16, 64'h0, 64'hFFFF_FFFF_FFFF_8877, 0, 2, 1, 0};
      vecs[3]  = '{1, 0, 3'b101, 64'h12, 64'h0, 64'h0000_0000_0000_4433, 0, 2, 1, 0};
      vecs[4]  = '{1, 0, 3'b010, 64'h14, 64'h0, 64'hFFFF_FFFF_8877_6655, 0, 2, 1, 0};
      vecs[5]  = '{1, 0, 3'b011, 64'h10, 64'h0, 64'h8877_6655_4433_2211, 0, 2, 1, 0};
      vecs[6]  = '{0, 1, 3'b001, 64'h12, 64'hFFFF_0000_1234_ABCD, 64'h0, 0, 3, 1, 2};
      vecs[7]  = '{1, 0, 3'b110, 64'h10, 64'h0, 64'h0000_0000_ABCD_2211, 0, 2, 1, 0};
      vecs[8]  = '{0, 1, 3'b011, 64'h18, 64'hDEAD_BEEF_0123_4567, 64'h0, 0, 2, 0, 1};
      vecs[9]  = '{1, 0, 3'b110, 64'h1C, 64'h0, 64'h0000_0000_DEAD_BEEF, 0, 2, 1, 0};
      vecs[10] = '{0, 1, 3'b000, 64'h19, 64'h1234_5678_9ABC_DEFF, 64'h0, 0, 3, 1, 2};
      vecs[11] = '{0, 1, 3'b010, 64'h1C, 64'h1111_2222_CAFE_F00D, 64'h0, 0, 3, 1, 2};
      vecs[12] = '{1, 0, 3'b000, 64'h1A, 64'h0, 64'h0000_0000_0000_0023, 0, 2, 1, 0};
      vecs[13] = '{1, 0, 3'b000, 64'h19, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 1, 0};
      vecs[14] = '{1, 0, 3'b001, 64'h1E, 64'h0, 64'hFFFF_FFFF_FFFF_CAFE, 0, 2, 1, 0};
      vecs[15] = '{1, 0, 3'b011, 64'h18, 64'h0, 64'hCAFE_F00D_0123_FF67, 0, 2, 1, 0};
      vecs[16] = '{1, 0, 3'b010, 64'h06, 64'h0, 64'h0, 1, 1, 0, 0};
      vecs[17] = '{0, 1, 3'b100, 64'h20, 64'h55, 64'h0, 1, 1, 0, 0};
      vecs[18] = '{1, 0, 3'b111, 64'h10, 64'h0, 64'h0, 1, 1, 0, 0};
      vecs[19] = '{1, 1, 3'b011, 64'h10, 64'h0, 64'h0, 1, 1, 0, 0};
      vecs[20] = '{1, 0, 3'b101, 64'h13, 64'h0, 64'h0, 1, 1, 0, 0};
      vecs[21] = '{1, 0, 3'b011, 64'h1C, 64'h0, 64'h0, 1, 1, 0, 0};
      vecs[22] = '{0, 0, 3'b000, 64'h10, 64'h0, 64'h0, 1, 1, 0, 0};

      scramble();
      reset = 1'b1;
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 10'd2; pl_val = 64'h8877_6655_4433_2211;
      @(negedge clk);
      pl_idx = 10'd3; pl_val = 64'h0;
      @(negedge clk);
      pl_en = 1'b0;
      chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
      chk("rst_mem_write", {63'd0, bus.mem_write}, 64'd0);
      chk("rst_mem_read", {63'd0, bus.mem_read}, 64'd0);
      chk("rst_mem_address", bus.mem_address, 64'd0);
      chk("rst_load_data", bus.load_data, 64'd0);
      reset = 1'b0;
      #1;
      chk("rst_req_ready_after", {63'd0, bus.req_ready}, 64'd1);

      for (int i = 0; i < 23; i++) apply(i, vecs[i]);

      chk("dmem2_after_sh", dmem[2], 64'h8877_6655_ABCD_2211);
      chk("dmem3_after_stores", dmem[3], 64'hCAFE_F00D_0123_FF67);

      // Sub-word store abandoned by reset in its READ cycle.
      @(negedge clk);
      drive(1'b0, 1'b1, 3'b000, 64'h18, 64'h55);
      @(negedge clk);
      scramble();
      chk("abandon_in_read", {63'd0, bus.mem_read}, 64'd1);
      reset = 1'b1;
      #1;
      chk("abandon_rst_mem_write", {63'd0, bus.mem_write}, 64'd0);
      chk("abandon_rst_resp", {63'd0, bus.resp_valid}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abandon_req_ready", {63'd0, bus.req_ready}, 64'd1);
      chk("abandon_mem_address", bus.mem_address, 64'd0);
      chk("abandon_mem_wdata", bus.mem_write_data, 64'd0);
      chk("abandon_fault", {63'd0, bus.fault}, 64'd0);
      wr_cnt = 0; rv_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.mem_write) wr_cnt++;
         if (bus.resp_valid) rv_cnt++;
      end
      chk("abandon_no_write", 64'(wr_cnt), 64'd0);
      chk("abandon_no_resp", 64'(rv_cnt), 64'd0);
      chk("abandon_dmem3", dmem[3], 64'hCAFE_F00D_0123_FF67);

      // Two loads with req_valid held: second accept waits for IDLE.
      rv = '0; rdy = '0;
      @(negedge clk);
      drive(1'b1, 1'b0, 3'b000, 64'h17, 64'h0);
      exp_q.push_back('{data: 64'hFFFF_FFFF_FFFF_FF88, fault: 1'b0});
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) drive(1'b1, 1'b0, 3'b011, 64'h10, 64'h0);
         rv[k]  = bus.resp_valid;
         rdy[k] = bus.req_ready;
         if (k == 3 && bus.req_ready) exp_q.push_back('{data: 64'h8877_6655_ABCD_2211, fault: 1'b0});
         if (k == 4) scramble();
      end
      chk("b2b_req_ready", {60'd0, rdy[4:1]}, 64'b0100);
      chk("b2b_resp_pattern", {58'd0, rv[6:1]}, 64'b010010);

      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit between the EX/MEM pipeline register and the data memory (dmem).
- Converts RV64I byte, half, word and double accesses into doubleword-indexed dmem accesses.
  - Loads: extracts and sign- or zero-extends the addressed field.
  - Sub-doubleword stores: read-modify-write, since dmem has no byte enables.
  - Misaligned or illegal requests: reported as a fault; no memory access.
- Holds the pipeline with req_ready low while busy.

Parameters:
- XLEN, 64, data/address width.
- DMEM_DEPTH, 1024, dmem entries. Doubleword index width = $clog2(DMEM_DEPTH).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present from MEM stage.
- req_ready  out  1  LSU can accept; high only in IDLE.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- funct3  in  3  RV funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- addr  in  XLEN  byte address (ALU result).
- store_data  in  XLEN  rs2 value; low bits used for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse.
- load_data  out  XLEN  extended load result; 0 for stores and faults.
- fault  out  1  qualified by resp_valid; misaligned or illegal request.
- mem_address  out  XLEN  doubleword index = {3'b0, addr[63:3]}.
- mem_read  out  1  dmem read enable.
- mem_write  out  1  dmem write enable.
- mem_write_data  out  XLEN  full doubleword to write.
- mem_read_data  in  XLEN  dmem read data, combinational from mem_address/mem_read.

Behaviour:

Request capture:
- Accepted when req_valid && req_ready.
- On accept, register addr, funct3, store_data, is_load and is_store. Inputs are ignored afterwards until the next accept.

FSM states: IDLE, READ, WRITE, RESP. Transitions from IDLE on accept:
- Fault → RESP with fault=1. Fault conditions:
  - H/HU with addr[0]≠0.
  - W/WU with addr[1:0]≠0.
  - D with addr[2:0]≠0.
  - funct3=111.
  - Store with funct3[2]=1.
  - is_load==is_store (both high or both low).
- Load → READ.
- Store with funct3=011 → WRITE. No read; mem_write_data = store_data.
- Other stores → READ.

READ state:
- mem_read=1. Capture mem_read_data into an internal doubleword register.
- Load → RESP. load_data is the addressed field, sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
  - Byte lane = addr[2:0]; half lane = addr[2:1]; word lane = addr[2].
- Store → WRITE. The captured doubleword is merged with store_data[7:0], [15:0] or [31:0] at the addressed lane; other bytes are preserved.

WRITE state:
- mem_write=1 for exactly one cycle with merged data → RESP.

RESP state:
- resp_valid=1 for one cycle, with load_data and fault valid → IDLE.
- req_ready returns high the following cycle.

Output defaults and address rules:
- mem_read and mem_write are 0 outside READ and WRITE.
- mem_address is driven from the registered addr in all non-IDLE states.

Latency, counted from accept cycle T:
- Load: resp_valid at T+2.
- Sub-word store: mem_write at T+2, resp_valid at T+3.
- SD: mem_write at T+1, resp_valid at T+2.
- Fault: resp_valid at T+1.

Reset (synchronous):
- Forces IDLE.
- resp_valid=0, fault=0, load_data=0, mem_read=0, mem_write=0, mem_write_data=0, mem_address=0, internal registers=0.
- req_ready=1 in the first cycle after reset deasserts.
- Reset during READ or WRITE abandons the operation. No mem_write occurs in or after the reset cycle, and no resp_valid is produced.

Edge cases:
- No back-to-back accept in RESP. A request held with req_valid high is accepted in the next IDLE cycle.
- A store's merge uses the data captured in READ. The LSU is the sole dmem writer, so there is no hazard.

Test Plan:
1. Preload dmem[2]=64'h8877_6655_4433_2211. LB addr=0x17 → resp_valid at T+2, load_data=64'hFFFF_FFFF_FFFF_FF88, fault=0. LBU same addr → 64'h88.
2. Preload as in 1. SH addr=0x12, store_data=0xABCD → mem_write at T+2 only. dmem[2]=64'h8877_6655_ABCD_2211; resp_valid at T+3.
3. SD addr=0x18, store_data=64'hDEAD_BEEF_0123_4567 → no mem_read, mem_write at T+1, dmem[3] updated. Then LWU addr=0x1C → 64'hDEAD_BEEF.
4. LW addr=0x06 → resp_valid at T+1, fault=1, load_data=0, mem_read and mem_write never asserted. Same for store with funct3=100.
5. Sub-word store accepted; assert reset in the READ cycle → no mem_write, no resp_valid, all outputs 0, req_ready=1 after reset.
6. Hold req_valid high with two queued loads → req_ready low for T+1..T+2, second accept at T+3, two resp_valid pulses at T+2 and T+5.
